// File: rtl/jy_mul_seq.sv
// rtl/jy_mul_seq.sv - 8x8 unsigned multiplier behind $5800/$5801 with save-state access
// Define JY_MUL_SEQ_FAST_EN to swap the 8-step shift-add engine for a one-clk combinational product.
module jy_mul_seq (
  input  logic        clk,
  input  logic        map_rst_n,
  input  logic        wr_stb,
  input  logic        wr_sel,
  input  logic [7:0]  wr_data,
  input  logic        sst_act,
  input  logic        sst_we,
  input  logic [1:0]  sst_addr,
  input  logic [7:0]  sst_dato,
  output logic [7:0]  arg_a,
  output logic [7:0]  arg_b,
  output logic [15:0] res,
  output logic        busy
);

  logic [7:0]  arg_a_q, arg_a_d;
  logic [7:0]  arg_b_q, arg_b_d;
  logic [15:0] res_q, res_d;
  logic        cpu_wr;
  logic        sst_wr;
  logic [7:0]  new_a;
  logic [7:0]  new_b;

  // A save-state session masks the CPU completely.
  assign cpu_wr = wr_stb && !sst_act;
  assign sst_wr = sst_we && sst_act;
  assign new_a  = (cpu_wr && !wr_sel) ? wr_data : arg_a_q;
  assign new_b  = (cpu_wr &&  wr_sel) ? wr_data : arg_b_q;

  always_comb begin
    arg_a_d = new_a;
    arg_b_d = new_b;
    if (sst_wr && (sst_addr == 2'd0)) arg_a_d = sst_dato;
    if (sst_wr && (sst_addr == 2'd1)) arg_b_d = sst_dato;
  end

  always_ff @(posedge clk or negedge map_rst_n) begin
    if (!map_rst_n) begin
      arg_a_q <= 8'h00;
      arg_b_q <= 8'h00;
      res_q   <= 16'h0000;
    end else begin
      arg_a_q <= arg_a_d;
      arg_b_q <= arg_b_d;
      res_q   <= res_d;
    end
  end

`ifdef JY_MUL_SEQ_FAST_EN

  logic        busy_q, busy_d;
  logic [15:0] prod;

  assign prod = {8'h00, new_a} * {8'h00, new_b};

  always_comb begin
    res_d  = res_q;
    busy_d = cpu_wr;
    if (cpu_wr) res_d = prod;
    if (sst_wr && (sst_addr == 2'd2)) res_d[7:0]  = sst_dato;
    if (sst_wr && (sst_addr == 2'd3)) res_d[15:8] = sst_dato;
  end

  always_ff @(posedge clk or negedge map_rst_n) begin
    if (!map_rst_n) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

`else

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] acc_sum;

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    res_d    = res_q;

    if (cpu_wr) begin
      // A write always (re)starts from step 0 with the freshly written operand.
      state_d  = RUN;
      acc_d    = 16'h0000;
      mcand_d  = {8'h00, new_a};
      mplier_d = new_b;
      cnt_d    = 3'd0;
    end else if (sst_act) begin
      // No run can start while sst_act is high, so holding IDLE here is the entry abort.
      state_d = IDLE;
    end else if (state_q == RUN) begin
      acc_d    = acc_sum;
      mcand_d  = {mcand_q[14:0], 1'b0};
      mplier_d = {1'b0, mplier_q[7:1]};
      cnt_d    = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        res_d   = acc_sum;
        state_d = IDLE;
      end
    end

    if (sst_wr && (sst_addr == 2'd2)) res_d[7:0]  = sst_dato;
    if (sst_wr && (sst_addr == 2'd3)) res_d[15:8] = sst_dato;
  end

  always_ff @(posedge clk or negedge map_rst_n) begin
    if (!map_rst_n) begin
      state_q  <= IDLE;
      acc_q    <= 16'h0000;
      mcand_q  <= 16'h0000;
      mplier_q <= 8'h00;
      cnt_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);

`endif

  assign arg_a = arg_a_q;
  assign arg_b = arg_b_q;
  assign res   = res_q;

endmodule

// File: doc/jy_mul_seq.md
# jy_mul_seq

Sequential 8x8 unsigned multiplier controller for the mapper 090-family ASIC register file. It owns the two argument registers and the 16-bit product register behind $5800/$5801. It arbitrates between CPU writes and save-state access, and sequences a shift-add datapath over 8 clocks so the product never needs a single-cycle 8x8 array. It sits between the mapper register decode (which supplies qualified strobes) and the CPU read mux (which consumes `res` and `busy`).

## Interface
- No parameters.
- `clk`  in  1  mapper system clock.
- `map_rst_n`  in  1  asynchronous, active-low reset.
- `wr_stb`  in  1  CPU write to an argument; one-clk pulse, already qualified by M2 edge and !rw.
- `wr_sel`  in  1  0 = arg A ($5800), 1 = arg B ($5801).
- `wr_data`  in  8  CPU write data.
- `sst_act`  in  1  save-state session active.
- `sst_we`  in  1  save-state register write strobe, one clk.
- `sst_addr`  in  2  0 = arg A, 1 = arg B, 2 = res[7:0], 3 = res[15:8].
- `sst_dato`  in  8  save-state write data.
- `arg_a`, `arg_b`  out  8  current argument registers (save-state readback).
- `res`  out  16  product register.
- `busy`  out  1  multiply in progress.

## Operation
- FSM states: IDLE, RUN.
- Datapath registers:
  - `acc[15:0]` holds the partial product.
  - `mcand[15:0]` holds arg A zero-extended and shifted left once per step.
  - `mplier[7:0]` holds arg B shifted right once per step.
  - `cnt[2:0]` counts the steps.
- Entering RUN: acc = 0, mcand = {8'h00, A}, mplier = B, cnt = 0, busy = 1.
- Each RUN clk:
  - If mplier[0] is set, acc += mcand (16-bit, no carry out).
  - mcand <<= 1, mplier >>= 1, cnt++.
  - On the clk where cnt == 7, `res` takes the final acc value, the FSM returns to IDLE, and busy drops.
- `res` holds its previous value for the whole RUN and changes only on completion. No partial products are ever visible.
- CPU write, any state, with sst_act = 0:
  - The selected arg register is loaded.
  - The FSM enters RUN using the new value of that argument and the held value of the other. This restarts any run in progress.
- Save-state priority:
  - While sst_act = 1, CPU strobes are ignored.
  - The rising edge of sst_act aborts any RUN to IDLE with `res` unchanged.
  - sst_we writes the addressed register directly and never starts a multiply.
- If wr_stb and sst_we assert in the same clk while sst_act = 1, only sst_we takes effect.

## Timing
- Write strobe in clk N → busy = 1 from N+1 → `res` valid and busy = 0 from N+9. Latency is 8 clks after the strobe clk.
- A restart during RUN resets the step count. Completion is then 8 clks after the latest strobe.
- At 6502 speed, a CPU read can never occur within 8 clks of a write, so no wait handshake to the CPU exists. `busy` is informational and used by verification.
- Reset (async assert, mid-operation included) forces every output and register to reset value:
  - arg_a = 0, arg_b = 0, res = 0, busy = 0, state IDLE.
  - acc, mcand, mplier and cnt are all cleared.
- Deassertion is synchronized externally. The first active edge after release sees IDLE.

## Configuration
- `JY_MUL_SEQ_FAST_EN` defined: the shift-add engine is not built.
  - A write strobe in clk N loads `res` with A*B, computed combinationally, at clk N+1.
  - busy is high for exactly clk N+1's cycle only.
  - Save-state rules are unchanged.
- Not defined: the 8-step sequential engine described above.
- Both builds must produce an identical `res` for identical stimulus once busy = 0.

## Test plan
- Reset, then write A = 0x12 and B = 0x34 → busy high for 8 clks after the second strobe; `res` = 0x03A8; `res` equals the first-product value (0x0000) until completion.
- A = 0xFF, B = 0xFF → `res` = 0xFE01. Then B = 0x00 → `res` = 0x0000.
- A = 0x10, B = 0x10, then 3 clks later B = 0x02 → exactly one completion, 8 clks after the last strobe, with `res` = 0x0020; 0x0100 never appears.
- During a RUN, assert sst_act → busy = 0 next clk and `res` unchanged. Then sst_we writes 0xCD to addr 3 and 0xAB to addr 2 → `res` = 0xCDAB, busy stays 0. A simultaneous wr_stb is ignored.
- Assert map_rst_n low 4 clks into a RUN → all outputs 0 immediately (asynchronous); no completion occurs after release.
- Build with `JY_MUL_SEQ_FAST_EN` and repeat the 0x12 × 0x34 case → `res` = 0x03A8 at strobe + 1 clk.
